// File: rtl/fact_sched.sv
// ============================================================================
// fact_sched : round-robin arbiter in front of one iterative 8-bit factorial
//              engine (n! mod 256 plus overflow flag).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module fact_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    n_in,
    output logic [NREQ-1:0]      ack,
    output logic                 done,
    output logic [7:0]           result,
    output logic                 ovf,
    output logic [IDW-1:0]       done_id,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    gid_q;
    logic [7:0]        acc_q;
    logic [7:0]        cnt_q;
    logic              ovf_r_q;

    logic [NREQ-1:0]   ack_q;
    logic              done_q;
    logic [7:0]        result_q;
    logic              ovf_q;
    logic [IDW-1:0]    done_id_q;

    logic              found_d;
    logic [IDW-1:0]    gnt_d;
    logic [7:0]        n_sel_d;
    logic [15:0]       prod_d;

    // Index k positions above p, wrapping at NREQ (NREQ need not be a power of 2).
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return s[IDW-1:0];
    endfunction

    // Scan downward so the candidate closest to ptr is the last one written.
    always_comb begin
        found_d = 1'b0;
        gnt_d   = '0;
        n_sel_d = 8'd0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (req[rr_idx(ptr_q, k)]) begin
                found_d = 1'b1;
                gnt_d   = rr_idx(ptr_q, k);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_d == k[IDW-1:0]) n_sel_d = n_in[8*k +: 8];
        end
    end

    assign prod_d = {8'd0, acc_q} * {8'd0, cnt_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gid_q     <= '0;
            acc_q     <= 8'd0;
            cnt_q     <= 8'd0;
            ovf_r_q   <= 1'b0;
            ack_q     <= '0;
            done_q    <= 1'b0;
            result_q  <= 8'd0;
            ovf_q     <= 1'b0;
            done_id_q <= '0;
        end else begin
            ack_q     <= '0;
            done_q    <= 1'b0;
            result_q  <= 8'd0;
            ovf_q     <= 1'b0;
            done_id_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        gid_q   <= gnt_d;
                        ptr_q   <= rr_idx(gnt_d, 1);
                        acc_q   <= 8'd1;
                        cnt_q   <= n_sel_d;
                        ovf_r_q <= 1'b0;
                        state_q <= S_MULT;
                    end
                end
                S_MULT: begin
                    if (cnt_q <= 8'd1) begin
                        // Result outputs are loaded here so they are valid for the whole DONE cycle.
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        ack_q     <= {{(NREQ-1){1'b0}}, 1'b1} << gid_q;
                        result_q  <= acc_q;
                        ovf_q     <= ovf_r_q;
                        done_id_q <= gid_q;
                    end else begin
                        acc_q   <= prod_d[7:0];
                        ovf_r_q <= ovf_r_q | (|prod_d[15:8]);
                        cnt_q   <= cnt_q - 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign result  = result_q;
    assign ovf     = ovf_q;
    assign done_id = done_id_q;
    assign busy    = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fact_sched.sv
// ============================================================================
// tb_fact_sched : self-checking bench for fact_sched against a job-level model.
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fact_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [8*NREQ-1:0]   n_in;
    logic [NREQ-1:0]     ack;
    logic                done;
    logic [7:0]          result;
    logic                ovf;
    logic [IDW-1:0]      done_id;
    logic                busy;

    fact_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .n_in    (n_in),
        .ack     (ack),
        .done    (done),
        .result  (result),
        .ovf     (ovf),
        .done_id (done_id),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Job-level reference: one job at a time, done max(n,1) edges after the
    // grant edge, engine free for a new grant two edges after the done edge.
    bit m_act       = 1'b0;
    int m_done_edge = 0;
    int m_ptr       = 0;
    int m_gid       = 0;
    int m_n         = 0;
    int served[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic int fact_mod(input int n);
        int a = 1;
        for (int i = 2; i <= n; i++) a = (a * i) % 256;
        return a;
    endfunction

    function automatic bit fact_big(input int n);
        longint t = 1;
        for (int i = 2; i <= n; i++) begin
            t = t * i;
            if (t > 255) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic tick();
        logic [NREQ-1:0]   rv;
        logic [8*NREQ-1:0] nv;
        logic              rs;
        bit                e_done;
        bit                e_busy;
        rv = req;
        nv = n_in;
        rs = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (rs) begin
            m_act = 1'b0;
            m_ptr = 0;
        end else if (!m_act || cyc > m_done_edge + 1) begin
            m_act = 1'b0;
            if (rv != '0) begin
                m_gid       = rr_pick(rv, m_ptr);
                m_n         = int'(nv[8*m_gid +: 8]);
                m_done_edge = cyc + ((m_n > 1) ? m_n : 1);
                m_ptr       = (m_gid + 1) % NREQ;
                m_act       = 1'b1;
            end
        end
        e_done = m_act && (cyc == m_done_edge);
        e_busy = m_act && (cyc <= m_done_edge);
        check("done",    done,    e_done);
        check("busy",    busy,    e_busy);
        check("ack",     ack,     e_done ? (32'd1 << m_gid) : 32'd0);
        check("result",  result,  e_done ? fact_mod(m_n) : 0);
        check("ovf",     ovf,     e_done ? fact_big(m_n) : 1'b0);
        check("done_id", done_id, e_done ? m_gid : 0);
        if (done) served.push_back(int'(done_id));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic do_job(input int idx, input int n);
        bit got = 1'b0;
        req[idx]          = 1'b1;
        n_in[8*idx +: 8]  = n[7:0];
        for (int t = 0; t < 400 && !got; t++) begin
            tick();
            if (ack[idx]) got = 1'b1;
        end
        check("job_ack_seen", got, 1'b1);
        req[idx] = 1'b0;
        tick();
    endtask

    initial begin
        bit got;
        rst  = 1'b1;
        req  = '0;
        n_in = '0;
        do_reset(3);

        do_job(0, 5);
        do_job(0, 0);
        do_job(0, 1);
        do_job(0, 6);
        do_job(0, 10);
        do_job(1, 3);

        // All requesters held with n=3: strict rotation starting at 0.
        do_reset(1);
        served.delete();
        req  = 4'hF;
        n_in = {8'd3, 8'd3, 8'd3, 8'd3};
        for (int t = 0; t < 80 && served.size() < 8; t++) tick();
        req = '0;
        repeat (3) tick();
        check("rr_count", served.size(), 8);
        for (int i = 0; i < served.size() && i < 8; i++) check("rr_order", served[i], i % 4);

        // Reset two cycles into a 7! job, then the held request is re-served.
        do_reset(1);
        req       = 4'b0001;
        n_in[7:0] = 8'd7;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("busy_after_rst", busy, 1'b0);
        rst = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 30 && !got; t++) begin
            tick();
            if (ack[0]) begin
                got = 1'b1;
                check("n7_result", result, 8'hB0);
                check("n7_ovf", ovf, 1'b1);
            end
        end
        check("n7_ack_seen", got, 1'b1);
        req = '0;
        tick();

        // One-cycle pulse on req[2]: job still completes.
        do_reset(1);
        served.delete();
        req         = 4'b0100;
        n_in[23:16] = 8'd4;
        tick();
        req = '0;
        repeat (8) tick();
        check("pulse_served", served.size(), 1);
        if (served.size() > 0) check("pulse_id", served[0], 2);

        // Randomized traffic with occasional mid-job drops and resets.
        for (int t = 0; t < 3000; t++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (ack[i]) begin
                        if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    end else if ($urandom_range(0, 99) == 0) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 15) == 0) n_in[8*i +: 8] = 8'($urandom_range(0, 255));
                    else                            n_in[8*i +: 8] = 8'($urandom_range(0, 12));
                    req[i] = 1'b1;
                end
            end
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        req = '0;
        repeat (300) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
